deser_8bit: RTL and testbench



---
 rtl/deser_8bit_pkg.sv | 4 +
 rtl/dff_en.sv | 17 +
 rtl/deser_8bit.sv | 46 ++++
 tb/tb_deser_8bit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/deser_8bit_pkg.sv
// deser_8bit_pkg: shared word-width constant for the deserializer slice.
package deser_8bit_pkg;
  localparam int unsigned WORD_W = 8;
endpackage

// File: rtl/dff_en.sv
// dff_en: D flip-flop with synchronous enable (2:1 mux feedback) and synchronous active-high reset.
module dff_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  assign q_d = en ? d : q_q;
  always_ff @(posedge clk)
    q_q <= reset ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/deser_8bit.sv
// deser_8bit: serial-to-parallel front stage; collects one bit per valid clock and
// presents each completed word on dout with a one-cycle strobe, parking it while dout_hold is high.
module deser_8bit
  import deser_8bit_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     sync,
  input  logic                     dout_hold,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_strobe,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr_q, sr_d, hold_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d, inc, c;
  logic             pend_q, pend_d, complete, load;
  assign sr_d = LSB_FIRST ? {din, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], din};
  // ripple half-adder chain: cnt + 1, wrapping naturally at WIDTH
  assign c[0] = 1'b1;
  for (genvar i = 0; i < CW; i++) begin : g_inc
    assign inc[i] = cnt_q[i] ^ c[i];
    if (i < CW - 1) begin : g_c
      assign c[i+1] = cnt_q[i] & c[i];
    end
  end
  assign cnt_d    = sync ? {{(CW-1){1'b0}}, 1'b1} : inc;
  assign complete = din_valid & ~sync & (&cnt_q);
  assign load     = ~dout_hold & (complete | pend_q);
  assign dout_d   = complete ? sr_d : hold_q;
  assign pend_d   = dout_hold & (complete | pend_q);
  dff_en #(.W(WIDTH)) u_sr   (.clk(clk), .reset(reset), .en(din_valid),            .d(sr_d),   .q(sr_q));
  dff_en #(.W(CW))    u_cnt  (.clk(clk), .reset(reset), .en(din_valid),            .d(cnt_d),  .q(cnt_q));
  dff_en #(.W(WIDTH)) u_hold (.clk(clk), .reset(reset), .en(complete & dout_hold), .d(sr_d),   .q(hold_q));
  dff_en #(.W(WIDTH)) u_dout (.clk(clk), .reset(reset), .en(load),                 .d(dout_d), .q(dout));
  dff_en #(.W(1))     u_pend (.clk(clk), .reset(reset), .en(1'b1),                 .d(pend_d), .q(pend_q));
  dff_en #(.W(1))     u_stb  (.clk(clk), .reset(reset), .en(1'b1),                 .d(load),   .q(dout_strobe));
  dff_en #(.W(1))     u_ovr  (.clk(clk), .reset(reset), .en(complete & pend_q),    .d(1'b1),   .q(overrun));
  assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_deser_8bit.sv
// tb_deser_8bit: directed and randomized checks of both bit orders against a word-level model.
module tb_deser_8bit;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0, din_valid = 1'b0, sync = 1'b0, dout_hold = 1'b0;
  logic [7:0] dout1, dout0;
  logic [2:0] cnt1, cnt0;
  logic       stb1, stb0, ovr1, ovr0;
  int checks = 0, errors = 0, stb_seen = 0;
  bit         mbits [8];
  int         mn = 0;
  logic [7:0] m_dout1 = 0, m_dout0 = 0, m_park1 = 0, m_park0 = 0;
  bit         m_pend = 0, m_ovr = 0, m_stb = 0;

  always #5 clk = ~clk;

  deser_8bit #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync), .dout_hold(dout_hold),
    .dout(dout1), .dout_strobe(stb1), .bit_cnt(cnt1), .overrun(ovr1));
  deser_8bit #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync), .dout_hold(dout_hold),
    .dout(dout0), .dout_strobe(stb0), .bit_cnt(cnt0), .overrun(ovr0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: bits are gathered in arrival order and packed once eight are present.
  task automatic model_step();
    bit done;
    logic [7:0] w1, w0;
    if (reset) begin
      mn = 0; m_dout1 = 0; m_dout0 = 0; m_pend = 0; m_ovr = 0; m_stb = 0;
      return;
    end
    done = 0;
    if (din_valid) begin
      if (sync) mn = 0;
      mbits[mn] = din;
      mn++;
      if (mn == 8) begin done = 1; mn = 0; end
    end
    w1 = 0; w0 = 0;
    for (int i = 0; i < 8; i++) begin
      w1[i]     = mbits[i];
      w0[7 - i] = mbits[i];
    end
    m_stb = 0;
    if (done) begin
      if (m_pend) m_ovr = 1;
      if (!dout_hold) begin m_dout1 = w1; m_dout0 = w0; m_stb = 1; m_pend = 0; end
      else begin m_park1 = w1; m_park0 = w0; m_pend = 1; end
    end else if (m_pend && !dout_hold) begin
      m_dout1 = m_park1; m_dout0 = m_park0; m_stb = 1; m_pend = 0;
    end
  endtask

  task automatic cycle(input bit v, input bit d, input bit s, input bit h);
    din_valid = v; din = d; sync = s; dout_hold = h;
    @(posedge clk);
    model_step();
    #1;
    check("dout_lsb", dout1, m_dout1);
    check("dout_msb", dout0, m_dout0);
    check("strobe_lsb", stb1, m_stb);
    check("strobe_msb", stb0, m_stb);
    check("bit_cnt_lsb", cnt1, mn);
    check("bit_cnt_msb", cnt0, mn);
    check("overrun_lsb", ovr1, m_ovr);
    check("overrun_msb", ovr0, m_ovr);
    if (stb1) stb_seen++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input bit h);
    for (int i = 0; i < n; i++) cycle(1, w[i], i == 0, h);
  endtask

  initial begin
    do_reset();
    check("rst_dout", dout1, 8'h00);
    check("rst_strobe", stb1, 1'b0);
    check("rst_cnt", cnt1, 3'd0);
    check("rst_ovr", ovr1, 1'b0);
    // 1,0,1,1,0,0,1,0 in arrival order
    stb_seen = 0;
    send_bits(8'h4D, 8, 0);
    check("s1_strobe", stb1, 1'b1);
    check("s1_dout_lsb", dout1, 8'h4D);
    check("s1_dout_msb", dout0, 8'hB2);
    check("s1_cnt", cnt1, 3'd0);
    cycle(0, 0, 0, 0);
    check("s1_strobe_fall", stb1, 1'b0);
    check("s1_one_strobe", stb_seen, 1);
    // same word with idle gaps
    stb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      automatic logic [7:0] w = 8'h4D;
      cycle(1, w[i], i == 0, 0);
      if (i < 7) begin
        for (int g = $urandom_range(1, 3); g > 0; g--) begin
          cycle(0, 1'($urandom), 0, 0);
          check("s2_gap_cnt", cnt1, i + 1);
        end
      end
    end
    check("s2_dout", dout1, 8'h4D);
    check("s2_one_strobe", stb_seen, 1);
    // partial word abandoned by sync
    stb_seen = 0;
    send_bits(8'($urandom), 5, 0);
    send_bits(8'hFF, 8, 0);
    check("s3_dout", dout1, 8'hFF);
    check("s3_ovr", ovr1, 1'b0);
    check("s3_one_strobe", stb_seen, 1);
    // two words parked under hold
    do_reset();
    stb_seen = 0;
    send_bits(8'h11, 8, 1);
    send_bits(8'h22, 8, 1);
    check("s4_dout_held", dout1, 8'h00);
    check("s4_no_strobe", stb_seen, 0);
    check("s4_ovr", ovr1, 1'b1);
    cycle(0, 0, 0, 0);
    check("s4_release_strobe", stb1, 1'b1);
    check("s4_dout", dout1, 8'h22);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    check("s4_ovr_sticky", ovr1, 1'b1);
    check("s4_one_strobe", stb_seen, 1);
    // reset mid-word
    send_bits(8'h3C, 4, 0);
    do_reset();
    check("s5_ovr_clear", ovr1, 1'b0);
    stb_seen = 0;
    send_bits(8'hA5, 7, 0);
    check("s5_dout_zero", dout1, 8'h00);
    check("s5_no_strobe", stb_seen, 0);
    cycle(1, 1'b1, 0, 0);
    check("s5_dout", dout1, 8'hA5);
    check("s5_strobe", stb1, 1'b1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) dout_hold = ~dout_hold;
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0, dout_hold);
      reset = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
